// File: rtl/rover_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rover_pkg
// Description : Definitions shared between the IR command receiver and the
//               rover motor sequencer. It covers the motion-command field
//               split, the frame geometry, the frame FSM state encoding and
//               the burst classification codes.
// Revision    : 1.0 - initial release
// ============================================================================
package rover_pkg;

    // Motion command layout: [11:7] angle, [6:0] distance
    localparam int CMD_WIDTH  = 12;
    localparam int FRAME_BITS = 12;
    localparam int ANGLE_MSB  = 11;
    localparam int ANGLE_LSB  = 7;
    localparam int DIST_MSB   = 6;

    // Frame FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_GAP   = 3'd1;
    localparam logic [2:0] ST_BIT   = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ABORT = 3'd4;

    // Classification of a completed burst by its measured length
    typedef enum logic [1:0] {
        CLS_BAD   = 2'd0,
        CLS_ZERO  = 2'd1,
        CLS_ONE   = 2'd2,
        CLS_START = 2'd3
    } pulse_class_t;

endpackage : rover_pkg
`default_nettype wire

// File: rtl/ir_command_receiver_if.sv
`default_nettype none
// ============================================================================
// Interface   : ir_command_receiver_if
// Description : Groups the signals of the IR command receiver.
//               ir_in_n       - raw sensor output, low while a carrier is seen
//               command       - last valid decoded command
//               command_ready - one-cycle strobe when command updates
//               frame_error   - one-cycle strobe when a frame is aborted
//               The master modport is the sensor/consumer side. The slave
//               modport is the receiver.
// Revision    : 1.0 - initial release
// ============================================================================
interface ir_command_receiver_if;
    import rover_pkg::*;

    logic                 ir_in_n;
    logic [CMD_WIDTH-1:0] command;
    logic                 command_ready;
    logic                 frame_error;

    modport master (
        output ir_in_n,
        input  command,
        input  command_ready,
        input  frame_error
    );

    modport slave (
        input  ir_in_n,
        output command,
        output command_ready,
        output frame_error
    );

endinterface : ir_command_receiver_if
`default_nettype wire

// File: rtl/ir_pulse_timer.sv
`default_nettype none
// ============================================================================
// Module      : ir_pulse_timer
// Description : Front end of the IR receiver. It synchronizes the raw sensor,
//               detects burst edges and measures burst and gap lengths with a
//               saturating half-rate counter. It classifies each burst as it
//               ends.
// Ports       : clock, reset                - system clock, sync reset
//               ir_in_n_i                   - raw asynchronous sensor input
//               burst_o                     - synchronized carrier-present
//               burst_start_o/burst_end_o   - single-cycle edge strobes
//               class_o                     - class of the current length
//               gap_timeout_o/burst_timeout_o - length limit exceeded
// Revision    : 1.0 - initial release
// ============================================================================
module ir_pulse_timer
    import rover_pkg::*;
#(
    parameter int UNIT_CYCLES = 16200
) (
    input  wire logic   clock,
    input  wire logic   reset,
    input  wire logic   ir_in_n_i,
    output logic        burst_o,
    output logic        burst_start_o,
    output logic        burst_end_o,
    output pulse_class_t class_o,
    output logic        gap_timeout_o,
    output logic        burst_timeout_o
);

    localparam int CNT_W = 17;

    // The counter advances every other cycle, so one unit U spans
    // UNIT_CYCLES/2 counts. Every threshold below is written in counts.
    localparam logic [CNT_W-1:0] START_MIN = CNT_W'(3 * UNIT_CYCLES / 2);
    localparam logic [CNT_W-1:0] START_MAX = CNT_W'(5 * UNIT_CYCLES / 2);
    localparam logic [CNT_W-1:0] ONE_MIN   = CNT_W'(3 * UNIT_CYCLES / 4);
    localparam logic [CNT_W-1:0] ONE_LIM   = CNT_W'(5 * UNIT_CYCLES / 4);
    localparam logic [CNT_W-1:0] ZERO_MIN  = CNT_W'(UNIT_CYCLES / 4);
    localparam logic [CNT_W-1:0] ZERO_LIM  = CNT_W'(3 * UNIT_CYCLES / 4);
    localparam logic [CNT_W-1:0] GAP_MAX   = CNT_W'(UNIT_CYCLES);
    localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(5 * UNIT_CYCLES / 2);

    logic             sync1_q, sync2_q;
    logic             burst_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;
    logic             edge_w;

    assign burst_o       = ~sync2_q;
    assign burst_start_o =  burst_o & ~burst_q;
    assign burst_end_o   = ~burst_o &  burst_q;
    assign edge_w        = burst_start_o | burst_end_o;

    // The synchronizer resets to the idle (no carrier) level, so leaving
    // reset never produces a spurious edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            burst_q <= 1'b0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            sync1_q <= ir_in_n_i;
            sync2_q <= sync1_q;
            burst_q <= burst_o;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = ~phase_q;
        if (edge_w) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (phase_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // The START and ONE ranges do not overlap, so the order of the tests
    // only matters for readability.
    always_comb begin
        class_o = CLS_BAD;
        if ((cnt_q >= START_MIN) && (cnt_q <= START_MAX)) begin
            class_o = CLS_START;
        end else if ((cnt_q >= ONE_MIN) && (cnt_q < ONE_LIM)) begin
            class_o = CLS_ONE;
        end else if ((cnt_q >= ZERO_MIN) && (cnt_q < ZERO_LIM)) begin
            class_o = CLS_ZERO;
        end
    end

    // These compare the raw count only. The consumer qualifies them with
    // the burst level, because the count means gap or burst length
    // depending on that level.
    assign gap_timeout_o   = (cnt_q > GAP_MAX);
    assign burst_timeout_o = (cnt_q > BURST_MAX);

endmodule : ir_pulse_timer
`default_nettype wire

// File: rtl/ir_command_receiver.sv
`default_nettype none
// ============================================================================
// Module      : ir_command_receiver
// Description : Decodes pulse-width IR frames into 12-bit motion commands.
//               A frame is a start burst followed by 12 data bits, LSB first.
//               Valid frames update command and pulse command_ready. Frames
//               aborted part way through pulse frame_error.
// Ports       : clock - system clock
//               reset - synchronous, active-high
//               bus   - slave side of ir_command_receiver_if
//                       (ir_in_n in, command/command_ready/frame_error out)
// Revision    : 1.0 - initial release
// ============================================================================
module ir_command_receiver
    import rover_pkg::*;
#(
    parameter int UNIT_CYCLES = 16200
) (
    input  wire logic             clock,
    input  wire logic             reset,
    ir_command_receiver_if.slave  bus
);

    logic         burst_w, burst_start_w, burst_end_w;
    logic         gap_timeout_w, burst_timeout_w;
    pulse_class_t class_w;

    logic [2:0]           state_q, state_d;
    logic [CMD_WIDTH-1:0] shift_q, shift_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [CMD_WIDTH-1:0] command_q, command_d;
    logic                 ready_q, ready_d;
    logic                 error_q, error_d;

    ir_pulse_timer #(
        .UNIT_CYCLES (UNIT_CYCLES)
    ) u_timer (
        .clock           (clock),
        .reset           (reset),
        .ir_in_n_i       (bus.ir_in_n),
        .burst_o         (burst_w),
        .burst_start_o   (burst_start_w),
        .burst_end_o     (burst_end_w),
        .class_o         (class_w),
        .gap_timeout_o   (gap_timeout_w),
        .burst_timeout_o (burst_timeout_w)
    );

    // State, shift register and bit count
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // Next state
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        case (state_q)
            ST_IDLE: begin
                // Bursts that are not START-length are ignored here without
                // raising an error.
                if (burst_end_w && (class_w == CLS_START)) begin
                    state_d   = ST_GAP;
                    shift_d   = '0;
                    bit_cnt_d = '0;
                end
            end
            ST_GAP: begin
                if (burst_start_w) begin
                    state_d = ST_BIT;
                end else if (!burst_w && gap_timeout_w) begin
                    state_d = ST_ABORT;
                end
            end
            ST_BIT: begin
                if (burst_end_w) begin
                    // A START-length burst inside a frame counts as BAD.
                    if ((class_w == CLS_ZERO) || (class_w == CLS_ONE)) begin
                        shift_d[bit_cnt_q] = (class_w == CLS_ONE);
                        bit_cnt_d          = bit_cnt_q + 4'd1;
                        state_d = (bit_cnt_q == 4'(FRAME_BITS - 1)) ? ST_DONE : ST_GAP;
                    end else begin
                        state_d = ST_ABORT;
                    end
                end else if (burst_w && burst_timeout_w) begin
                    state_d = ST_ABORT;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs: the strobes are decoded from the state and then registered,
    // so ready and error can never be high together.
    always_comb begin
        ready_d   = (state_q == ST_DONE);
        error_d   = (state_q == ST_ABORT);
        command_d = (state_q == ST_DONE) ? shift_q : command_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            command_q <= '0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            command_q <= command_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
        end
    end

    assign bus.command       = command_q;
    assign bus.command_ready = ready_q;
    assign bus.frame_error   = error_q;

endmodule : ir_command_receiver
`default_nettype wire

// File: tb/tb_ir_command_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_ir_command_receiver
// Description : Directed, self-checking bench for ir_command_receiver run at
//               UNIT_CYCLES = 20. Inputs are driven on the falling edge and
//               outputs are sampled on the falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ir_command_receiver;
    import rover_pkg::*;

    localparam int U = 20;

    logic clock = 1'b0;
    logic reset = 1'b1;

    ir_command_receiver_if bus_if ();

    ir_command_receiver #(
        .UNIT_CYCLES (U)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Pulse monitor: counts the strobes and logs each delivered command
    int         ready_cnt   = 0;
    int         error_cnt   = 0;
    int         overlap_cnt = 0;
    logic [11:0] cmd_log [16];

    always @(negedge clock) begin
        if (!reset) begin
            if (bus_if.command_ready) begin
                cmd_log[ready_cnt % 16] <= bus_if.command;
                ready_cnt               <= ready_cnt + 1;
            end
            if (bus_if.frame_error) error_cnt <= error_cnt + 1;
            if (bus_if.command_ready && bus_if.frame_error) overlap_cnt <= overlap_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic drive_burst(input int len);
        bus_if.ir_in_n = 1'b0;
        repeat (len) @(negedge clock);
        bus_if.ir_in_n = 1'b1;
    endtask

    // Sends a start burst and then nbits data bits. One bit can be replaced
    // by a burst of bad_len cycles, and the gap after one bit can be
    // stretched. The task returns on the raw rising edge that ends the
    // last burst.
    task automatic send_frame(input logic [11:0] cmd, input int start_len, input int nbits,
                              input int bad_bit, input int bad_len,
                              input int gap_bit, input int gap_len);
        drive_burst(start_len);
        idle(U);
        for (int i = 0; i < nbits; i++) begin
            int len;
            len = (i == bad_bit) ? bad_len : (cmd[i] ? 2 * U : U);
            drive_burst(len);
            if (i != nbits - 1) idle((i == gap_bit) ? gap_len : U);
        end
    endtask

    int r0, e0;

    initial begin
        bus_if.ir_in_n = 1'b1;
        reset = 1'b1;
        idle(4);
        reset = 1'b0;
        @(negedge clock);

        // Reset state
        check_eq("reset_command", 32'(bus_if.command), 32'h000);
        check_eq("reset_ready",   32'(bus_if.command_ready), 32'd0);
        check_eq("reset_error",   32'(bus_if.frame_error), 32'd0);
        check_eq("reset_state",   32'(dut.state_q), 32'(ST_IDLE));
        idle(10);

        // Valid frame with exact strobe timing
        r0 = ready_cnt; e0 = error_cnt;
        send_frame(12'hA53, 4 * U, 12, -1, 0, -1, 0);
        idle(3);
        check_eq("valid_ready_early", 32'(bus_if.command_ready), 32'd0);
        @(negedge clock);
        check_eq("valid_ready_pulse", 32'(bus_if.command_ready), 32'd1);
        check_eq("valid_command",     32'(bus_if.command), 32'hA53);
        check_eq("valid_no_error",    32'(bus_if.frame_error), 32'd0);
        @(negedge clock);
        check_eq("valid_ready_width", 32'(bus_if.command_ready), 32'd0);
        idle(60);
        check_eq("valid_ready_count", 32'(ready_cnt - r0), 32'd1);
        check_eq("valid_error_count", 32'(error_cnt - e0), 32'd0);

        // Glitch of 6 cycles in bit 5, with the frame cut at that bit
        r0 = ready_cnt; e0 = error_cnt;
        send_frame(12'h3C5, 4 * U, 6, 5, 6, -1, 0);
        idle(3);
        check_eq("glitch_error_early", 32'(bus_if.frame_error), 32'd0);
        @(negedge clock);
        check_eq("glitch_error_pulse", 32'(bus_if.frame_error), 32'd1);
        check_eq("glitch_no_ready",    32'(bus_if.command_ready), 32'd0);
        @(negedge clock);
        check_eq("glitch_error_width", 32'(bus_if.frame_error), 32'd0);
        idle(60);
        check_eq("glitch_error_count", 32'(error_cnt - e0), 32'd1);
        check_eq("glitch_ready_count", 32'(ready_cnt - r0), 32'd0);
        check_eq("glitch_cmd_kept",    32'(bus_if.command), 32'hA53);

        // Gap timeout after bit 3, then recovery with the next frame
        r0 = ready_cnt; e0 = error_cnt;
        send_frame(12'h0F0, 4 * U, 12, -1, 0, 3, 45);
        idle(60);
        check_eq("gapto_error_count", 32'(error_cnt - e0), 32'd1);
        check_eq("gapto_ready_count", 32'(ready_cnt - r0), 32'd0);
        check_eq("gapto_cmd_kept",    32'(bus_if.command), 32'hA53);
        r0 = ready_cnt;
        send_frame(12'h07F, 4 * U, 12, -1, 0, -1, 0);
        idle(20);
        check_eq("gapto_next_command", 32'(bus_if.command), 32'h07F);
        check_eq("gapto_next_ready",   32'(ready_cnt - r0), 32'd1);

        // Short start burst: the whole frame is ignored
        r0 = ready_cnt; e0 = error_cnt;
        send_frame(12'h5A5, 50, 12, -1, 0, -1, 0);
        idle(40);
        check_eq("short_ready_count", 32'(ready_cnt - r0), 32'd0);
        check_eq("short_error_count", 32'(error_cnt - e0), 32'd0);
        check_eq("short_state_idle",  32'(dut.state_q), 32'(ST_IDLE));
        check_eq("short_cmd_kept",    32'(bus_if.command), 32'h07F);

        // Reset after bit 6 discards the partial frame silently
        e0 = error_cnt;
        send_frame(12'hFFF, 4 * U, 7, -1, 0, -1, 0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        check_eq("rstmid_command", 32'(bus_if.command), 32'h000);
        check_eq("rstmid_ready",   32'(bus_if.command_ready), 32'd0);
        check_eq("rstmid_error",   32'(bus_if.frame_error), 32'd0);
        idle(60);
        check_eq("rstmid_no_error", 32'(error_cnt - e0), 32'd0);
        r0 = ready_cnt;
        send_frame(12'hFFF, 4 * U, 12, -1, 0, -1, 0);
        idle(20);
        check_eq("rstmid_next_command", 32'(bus_if.command), 32'hFFF);
        check_eq("rstmid_next_ready",   32'(ready_cnt - r0), 32'd1);

        // Back-to-back frames separated by a 1U gap
        r0 = ready_cnt; e0 = error_cnt;
        send_frame(12'h001, 4 * U, 12, -1, 0, -1, 0);
        idle(U);
        send_frame(12'h800, 4 * U, 12, -1, 0, -1, 0);
        idle(20);
        check_eq("b2b_ready_count", 32'(ready_cnt - r0), 32'd2);
        check_eq("b2b_first_cmd",   32'(cmd_log[r0 % 16]), 32'h001);
        check_eq("b2b_second_cmd",  32'(cmd_log[(r0 + 1) % 16]), 32'h800);
        check_eq("b2b_error_count", 32'(error_cnt - e0), 32'd0);

        check_eq("strobe_overlap", 32'(overlap_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_ir_command_receiver
`default_nettype wire
